// File: rtl/pc_stack.sv
// pc_stack: program counter with increment, load, relative branch and a call/return stack
module pc_stack #(
   parameter int W         = 8,
   parameter int STEP      = 1,
   parameter int DEPTH     = 4,
   parameter int RESET_VAL = 0,
   localparam int SPW      = $clog2(DEPTH + 1)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           en,
   input  logic           inc,
   input  logic           load,
   input  logic [W-1:0]   d,
   input  logic           branch,
   input  logic [W-1:0]   offset,
   input  logic           call,
   input  logic           ret,
   output logic [W-1:0]   q,
   output logic [SPW-1:0] sp,
   output logic           stk_full,
   output logic           stk_empty,
   output logic           stk_ovf,
   output logic           stk_unf
);
   localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   logic [W-1:0]   stk [DEPTH];
   logic [W-1:0]   q_inc, q_br;
   logic [SPW-1:0] sp_m1;
   logic           do_call, do_ret, push, pop;
   assign stk_full  = sp == SPW'(DEPTH);
   assign stk_empty = sp == '0;
   assign q_inc     = q + W'(STEP);
   assign q_br      = q + offset;
   assign sp_m1     = sp - SPW'(1);
   assign do_call   = en && !rst && !load && call;
   assign do_ret    = en && !rst && !load && !call && ret;
   assign push      = do_call && !stk_full;
   assign pop       = do_ret && !stk_empty;
   // Return addresses are written on a non-full call; storage survives reset, only sp is cleared
   always_ff @(posedge clk)
      if (push) stk[sp[AW-1:0]] <= q_inc;
   // PC, stack pointer and sticky error flags, one prioritised action per enabled cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         q       <= W'(RESET_VAL);
         sp      <= '0;
         stk_ovf <= 1'b0;
         stk_unf <= 1'b0;
      end else if (en) begin
         q       <= (load || call) ? d : ret ? (stk_empty ? q : stk[sp_m1[AW-1:0]]) : branch ? q_br : inc ? q_inc : q;
         sp      <= push ? sp + SPW'(1) : pop ? sp_m1 : sp;
         stk_ovf <= stk_ovf || (do_call && stk_full);
         stk_unf <= stk_unf || (do_ret && stk_empty);
      end
   end
endmodule

// File: tb/tb_pc_stack.sv
// tb_pc_stack: directed scenario checks for pc_stack with W=8, STEP=1, DEPTH=4
module tb_pc_stack;
   logic       clk = 0, rst = 0, en = 1, inc = 0, load = 0, branch = 0, call = 0, ret = 0;
   logic [7:0] d = 0, offset = 0, q;
   logic [2:0] sp;
   logic       stk_full, stk_empty, stk_ovf, stk_unf;
   int         tests = 0, fails = 0;

   pc_stack #(.W(8), .STEP(1), .DEPTH(4), .RESET_VAL(0)) dut (
      .clk(clk), .rst(rst), .en(en), .inc(inc), .load(load), .d(d), .branch(branch),
      .offset(offset), .call(call), .ret(ret), .q(q), .sp(sp), .stk_full(stk_full),
      .stk_empty(stk_empty), .stk_ovf(stk_ovf), .stk_unf(stk_unf));

   always #5 clk = ~clk;

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      {rst, inc, load, branch, call, ret} = '0;
      en = 1;
   endtask

   task automatic test_reset;
      idle();
      rst = 1; d = 8'h55; load = 1; cyc();
      idle();
      repeat (3) cyc();
      tests++; if (q !== 8'h00) begin fails++; $display("FAIL reset_q got %h want 00", q); end
      tests++; if (sp !== 3'd0) begin fails++; $display("FAIL reset_sp got %0d want 0", sp); end
      tests++; if ({stk_empty, stk_full, stk_ovf, stk_unf} !== 4'b1000) begin fails++; $display("FAIL reset_flags got %b want 1000", {stk_empty, stk_full, stk_ovf, stk_unf}); end
   endtask

   task automatic test_inc_wrap;
      logic [7:0] exp [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
      idle(); load = 1; d = 8'hFE; cyc();
      tests++; if (q !== exp[0]) begin fails++; $display("FAIL inc_load got %h want %h", q, exp[0]); end
      idle(); inc = 1;
      for (int i = 1; i < 4; i++) begin
         cyc();
         tests++; if (q !== exp[i]) begin fails++; $display("FAIL inc_%0d got %h want %h", i, q, exp[i]); end
      end
      en = 0; cyc();
      tests++; if (q !== 8'h01) begin fails++; $display("FAIL inc_en0 got %h want 01", q); end
      en = 0; inc = 0; call = 1; d = 8'hAA; cyc();
      tests++; if (q !== 8'h01 || sp !== 3'd0) begin fails++; $display("FAIL en0_call got q=%h sp=%0d want 01/0", q, sp); end
      idle();
   endtask

   task automatic test_branch;
      idle(); load = 1; d = 8'h10; cyc();
      idle(); branch = 1; offset = 8'hF0; cyc();
      tests++; if (q !== 8'h00) begin fails++; $display("FAIL branch_neg got %h want 00", q); end
      offset = 8'h05; inc = 1; cyc();
      tests++; if (q !== 8'h05) begin fails++; $display("FAIL branch_pos got %h want 05", q); end
      offset = 8'hFA; inc = 0; cyc();
      tests++; if (q !== 8'hFF) begin fails++; $display("FAIL branch_wrap got %h want FF", q); end
      idle();
   endtask

   task automatic test_call_ret;
      idle(); load = 1; d = 8'h20; cyc();
      idle(); call = 1; d = 8'h40; cyc();
      tests++; if (q !== 8'h40 || sp !== 3'd1) begin fails++; $display("FAIL call1 got q=%h sp=%0d want 40/1", q, sp); end
      d = 8'h60; cyc();
      tests++; if (q !== 8'h60 || sp !== 3'd2) begin fails++; $display("FAIL call2 got q=%h sp=%0d want 60/2", q, sp); end
      idle(); ret = 1; cyc();
      tests++; if (q !== 8'h41 || sp !== 3'd1) begin fails++; $display("FAIL ret1 got q=%h sp=%0d want 41/1", q, sp); end
      cyc();
      tests++; if (q !== 8'h21 || sp !== 3'd0 || stk_empty !== 1'b1) begin fails++; $display("FAIL ret2 got q=%h sp=%0d e=%b want 21/0/1", q, sp, stk_empty); end
      idle();
   endtask

   task automatic test_ovf_unf;
      logic [7:0] pops [5] = '{8'h83, 8'h82, 8'h81, 8'h22, 8'h22};
      idle(); call = 1;
      for (int i = 0; i < 5; i++) begin
         d = 8'h80 + 8'(i); cyc();
      end
      tests++; if (q !== 8'h84 || sp !== 3'd4 || stk_full !== 1'b1 || stk_ovf !== 1'b1) begin fails++; $display("FAIL ovf got q=%h sp=%0d f=%b o=%b want 84/4/1/1", q, sp, stk_full, stk_ovf); end
      tests++; if (stk_unf !== 1'b0) begin fails++; $display("FAIL ovf_unf got %b want 0", stk_unf); end
      idle(); ret = 1;
      for (int i = 0; i < 5; i++) begin
         cyc();
         tests++; if (q !== pops[i] || sp !== 3'(i < 4 ? 3 - i : 0)) begin fails++; $display("FAIL ret_%0d got q=%h sp=%0d want %h/%0d", i, q, sp, pops[i], i < 4 ? 3 - i : 0); end
      end
      tests++; if (stk_unf !== 1'b1 || stk_ovf !== 1'b1) begin fails++; $display("FAIL unf_sticky got u=%b o=%b want 1/1", stk_unf, stk_ovf); end
      idle(); rst = 1; cyc();
      idle();
      tests++; if ({stk_ovf, stk_unf} !== 2'b00 || q !== 8'h00) begin fails++; $display("FAIL flag_clear got o=%b u=%b q=%h want 0/0/00", stk_ovf, stk_unf, q); end
   endtask

   task automatic test_priority;
      idle(); load = 1; d = 8'h30; cyc();
      idle(); load = 1; call = 1; inc = 1; d = 8'h50; cyc();
      tests++; if (q !== 8'h50 || sp !== 3'd0) begin fails++; $display("FAIL load_call_inc got q=%h sp=%0d want 50/0", q, sp); end
      idle(); call = 1; ret = 1; d = 8'h70; cyc();
      tests++; if (q !== 8'h70 || sp !== 3'd1) begin fails++; $display("FAIL call_ret got q=%h sp=%0d want 70/1", q, sp); end
      idle(); ret = 1; branch = 1; offset = 8'h10; cyc();
      tests++; if (q !== 8'h51 || sp !== 3'd0) begin fails++; $display("FAIL ret_branch got q=%h sp=%0d want 51/0", q, sp); end
      idle(); branch = 1; inc = 1; offset = 8'h04; cyc();
      tests++; if (q !== 8'h55) begin fails++; $display("FAIL branch_inc got %h want 55", q); end
      idle(); call = 1; d = 8'h77; cyc();
      rst = 1; d = 8'h90; cyc();
      idle();
      tests++; if (q !== 8'h00 || sp !== 3'd0) begin fails++; $display("FAIL rst_call got q=%h sp=%0d want 00/0", q, sp); end
      ret = 1; cyc();
      tests++; if (q !== 8'h00 || stk_unf !== 1'b1) begin fails++; $display("FAIL ret_after_rst got q=%h u=%b want 00/1", q, stk_unf); end
      idle();
   endtask

   initial begin
      cyc();
      test_reset();
      test_inc_wrap();
      test_branch();
      test_call_ret();
      test_ovf_unf();
      test_priority();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
